fwd_scoreboard: RTL and testbench

- Parametrised next-generation forwarding and hazard unit for the AdamRiscv integer pipeline.
- Selects EX-stage operands from NFWD in-flight result sources, with the youngest source winning. Its outputs are operand data, not select codes.
- Keeps a per-register pending-write scoreboard for variable-latency producers (load miss, mul/div) and raises the ID stall when a needed source register has a pending write.
- Sits between the decode/issue logic, the EX operand muxes, and the writeback/completion path.

---
 rtl/fwd_scoreboard_if.sv | 52 +++++
 rtl/fwd_scoreboard.sv | 144 ++++++++++++++
 tb/tb_fwd_scoreboard.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// Bundle of ID, completion, EX-operand and forwarding-source signals for the
// forwarding/hazard unit. The pipeline side uses the master view and the
// scoreboard uses the slave view.
interface fwd_scoreboard_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int NFWD   = 3
);
    // ID / issue side
    logic                   id_valid;
    logic [REG_AW-1:0]      id_rs1;
    logic [REG_AW-1:0]      id_rs2;
    logic                   id_rs1_used;
    logic                   id_rs2_used;
    logic [REG_AW-1:0]      id_rd;
    logic                   id_long_lat;
    logic                   id_fire;
    logic                   flush;
    // long-latency completion
    logic                   cmp_valid;
    logic [REG_AW-1:0]      cmp_rd;
    // EX operand side
    logic [REG_AW-1:0]      ex_rs1;
    logic [REG_AW-1:0]      ex_rs2;
    logic [XLEN-1:0]        ex_rf1;
    logic [XLEN-1:0]        ex_rf2;
    // in-flight forwarding sources, index 0 youngest
    logic [NFWD-1:0]        fwd_valid;
    logic [NFWD*REG_AW-1:0] fwd_rd;
    logic [NFWD*XLEN-1:0]   fwd_data;
    // results
    logic [XLEN-1:0]        ex_op1;
    logic [XLEN-1:0]        ex_op2;
    logic [1:0]             ex_fwd_hit;
    logic                   id_stall;
    logic                   sb_busy;
    logic                   sb_err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_long_lat, id_fire, flush, cmp_valid, cmp_rd,
               ex_rs1, ex_rs2, ex_rf1, ex_rf2, fwd_valid, fwd_rd, fwd_data,
        input  ex_op1, ex_op2, ex_fwd_hit, id_stall, sb_busy, sb_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_long_lat, id_fire, flush, cmp_valid, cmp_rd,
               ex_rs1, ex_rs2, ex_rf1, ex_rf2, fwd_valid, fwd_rd, fwd_data,
        output ex_op1, ex_op2, ex_fwd_hit, id_stall, sb_busy, sb_err
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit: picks EX operands from the youngest matching
// in-flight result, and tracks pending writes from variable-latency producers
// in a per-register counter scoreboard that drives the ID stall.
module fwd_scoreboard #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int NFWD   = 3,
    parameter int CNT_W  = 2
) (
    input logic             clk,
    input logic             rst,
    fwd_scoreboard_if.slave bus
);
    localparam int NREG = 1 << REG_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // forwarding
    logic [XLEN-1:0]   op1_s;
    logic [XLEN-1:0]   op2_s;
    logic [1:0]        hit_s;
    logic              src_ok_s;
    logic              match1_s;
    logic              match2_s;
    logic [REG_AW-1:0] src_rd_s;

    // scoreboard
    logic [CNT_W-1:0]  cnt_r      [NREG];
    logic [CNT_W-1:0]  cnt_next_s [NREG];
    logic              inc_s;
    logic              dec_s;
    logic [NREG-1:0]   inc_vec_s;
    logic [NREG-1:0]   dec_vec_s;
    logic              err_evt_s;
    logic              busy_next_s;
    logic              sb_busy_r;
    logic              sb_err_r;

    // hazard detection
    logic [CNT_W-1:0]  cnt_rs1_s;
    logic [CNT_W-1:0]  cnt_rs2_s;
    logic [CNT_W-1:0]  cnt_rd_s;
    logic              pend1_s;
    logic              pend2_s;
    logic              sat_s;
    logic              stall_s;

    // Operand select: walk oldest to youngest so the youngest match overrides.
    // A destination of x0 never matches, so ex_rs==0 always reads the regfile.
    always_comb begin
        op1_s    = bus.ex_rf1;
        op2_s    = bus.ex_rf2;
        hit_s    = 2'b00;
        src_ok_s = 1'b0;
        match1_s = 1'b0;
        match2_s = 1'b0;
        src_rd_s = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            src_rd_s = bus.fwd_rd[k*REG_AW +: REG_AW];
            src_ok_s = bus.fwd_valid[k] && (src_rd_s != '0);
            match1_s = src_ok_s && (src_rd_s == bus.ex_rs1);
            match2_s = src_ok_s && (src_rd_s == bus.ex_rs2);
            op1_s    = match1_s ? bus.fwd_data[k*XLEN +: XLEN] : op1_s;
            op2_s    = match2_s ? bus.fwd_data[k*XLEN +: XLEN] : op2_s;
            hit_s[0] = hit_s[0] | match1_s;
            hit_s[1] = hit_s[1] | match2_s;
        end
    end

    // Scoreboard update requests; x0 is never tracked.
    assign inc_s     = bus.id_fire & ~bus.flush & bus.id_long_lat & (bus.id_rd != '0);
    assign dec_s     = bus.cmp_valid & (bus.cmp_rd != '0);
    assign inc_vec_s = inc_s ? (NREG'(1) << bus.id_rd)  : '0;
    assign dec_vec_s = dec_s ? (NREG'(1) << bus.cmp_rd) : '0;

    // Next counter values; inc+dec on the same register cancel, and
    // underflow/overflow hold the counter and flag an error instead.
    always_comb begin
        err_evt_s     = 1'b0;
        busy_next_s   = 1'b0;
        cnt_next_s[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_next_s[r] = cnt_r[r];
            if (inc_vec_s[r] && !dec_vec_s[r]) begin
                if (cnt_r[r] == CNT_MAX) begin
                    err_evt_s = 1'b1;
                end else begin
                    cnt_next_s[r] = cnt_r[r] + CNT_ONE;
                end
            end else if (dec_vec_s[r] && !inc_vec_s[r]) begin
                if (cnt_r[r] == '0) begin
                    err_evt_s = 1'b1;
                end else begin
                    cnt_next_s[r] = cnt_r[r] - CNT_ONE;
                end
            end else begin
                cnt_next_s[r] = cnt_r[r];
            end
            busy_next_s = busy_next_s | (cnt_next_s[r] != '0);
        end
    end

    // ID hazard: a source is pending unless its last outstanding write
    // completes this very cycle; a writer stalls when its counter is full.
    always_comb begin
        cnt_rs1_s = cnt_r[bus.id_rs1];
        cnt_rs2_s = cnt_r[bus.id_rs2];
        cnt_rd_s  = cnt_r[bus.id_rd];
        pend1_s   = (cnt_rs1_s != '0) &&
                    !(dec_vec_s[bus.id_rs1] && (cnt_rs1_s == CNT_ONE));
        pend2_s   = (cnt_rs2_s != '0) &&
                    !(dec_vec_s[bus.id_rs2] && (cnt_rs2_s == CNT_ONE));
        sat_s     = bus.id_long_lat && (bus.id_rd != '0) &&
                    (cnt_rd_s == CNT_MAX) && !dec_vec_s[bus.id_rd];
        stall_s   = bus.id_valid && ((bus.id_rs1_used && pend1_s) ||
                                     (bus.id_rs2_used && pend2_s) ||
                                     sat_s);
    end

    // Counter state, busy summary and sticky error with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= '0;
            end
            sb_busy_r <= 1'b0;
            sb_err_r  <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cnt_next_s[r];
            end
            sb_busy_r <= busy_next_s;
            sb_err_r  <= sb_err_r | err_evt_s;
        end
    end

    assign bus.ex_op1     = op1_s;
    assign bus.ex_op2     = op2_s;
    assign bus.ex_fwd_hit = hit_s;
    assign bus.id_stall   = stall_s;
    assign bus.sb_busy    = sb_busy_r;
    assign bus.sb_err     = sb_err_r;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a table of forwarding vectors plus
// hand-written sequences for stall, completion, saturation and reset.
module tb_fwd_scoreboard;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NFWD   = 3;
    localparam int CNT_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fwd_scoreboard_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NFWD(NFWD)) bus ();

    fwd_scoreboard #(.XLEN(XLEN), .REG_AW(REG_AW), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] data;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [1:0]  e_hit;
    } fwd_vec_t;

    fwd_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid    = 1'b0;
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_rs1_used = 1'b0;
        bus.id_rs2_used = 1'b0;
        bus.id_rd       = 5'd0;
        bus.id_long_lat = 1'b0;
        bus.id_fire     = 1'b0;
        bus.flush       = 1'b0;
        bus.cmp_valid   = 1'b0;
        bus.cmp_rd      = 5'd0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        bus.id_valid    = 1'b1;
        bus.id_rd       = rd;
        bus.id_long_lat = 1'b1;
        bus.id_fire     = 1'b1;
        tick();
        idle();
    endtask

    task automatic complete(input logic [4:0] rd);
        bus.cmp_valid = 1'b1;
        bus.cmp_rd    = rd;
        tick();
        idle();
    endtask

    task automatic read_regs(input logic [4:0] r1, input logic [4:0] r2);
        bus.id_valid    = 1'b1;
        bus.id_rs1      = r1;
        bus.id_rs2      = r2;
        bus.id_rs1_used = 1'b1;
        bus.id_rs2_used = 1'b1;
        #1;
    endtask

    initial begin
        vecs[0] = '{5'd5, 5'd6, 32'h111, 32'h222, 3'b111, {5'd5, 5'd5, 5'd5},
                    {32'd30, 32'd20, 32'd10}, 32'd10, 32'h222, 2'b01};
        vecs[1] = '{5'd5, 5'd6, 32'h111, 32'h222, 3'b110, {5'd5, 5'd5, 5'd5},
                    {32'd30, 32'd20, 32'd10}, 32'd20, 32'h222, 2'b01};
        vecs[2] = '{5'd5, 5'd6, 32'h111, 32'h222, 3'b100, {5'd5, 5'd5, 5'd5},
                    {32'd30, 32'd20, 32'd10}, 32'd30, 32'h222, 2'b01};
        vecs[3] = '{5'd3, 5'd0, 32'h111, 32'h0, 3'b111, {5'd3, 5'd3, 5'd0},
                    {32'h33, 32'h22, 32'hDEAD}, 32'h22, 32'h0, 2'b01};
        vecs[4] = '{5'd11, 5'd12, 32'hAAAA, 32'hBBBB, 3'b111, {5'd8, 5'd9, 5'd10},
                    {32'd1, 32'd2, 32'd3}, 32'hAAAA, 32'hBBBB, 2'b00};
        vecs[5] = '{5'd2, 5'd4, 32'h1, 32'h2, 3'b111, {5'd4, 5'd7, 5'd2},
                    {32'h444, 32'h777, 32'h222}, 32'h222, 32'h444, 2'b11};
        vecs[6] = '{5'd6, 5'd6, 32'h1, 32'h2, 3'b000, {5'd6, 5'd6, 5'd6},
                    {32'd3, 32'd2, 32'd1}, 32'h1, 32'h2, 2'b00};
        vecs[7] = '{5'd6, 5'd6, 32'h1, 32'h2, 3'b010, {5'd6, 5'd6, 5'd6},
                    {32'd3, 32'd2, 32'd1}, 32'd2, 32'd2, 2'b11};

        idle();
        bus.ex_rs1    = 5'd0;
        bus.ex_rs2    = 5'd0;
        bus.ex_rf1    = 32'd0;
        bus.ex_rf2    = 32'd0;
        bus.fwd_valid = 3'b000;
        bus.fwd_rd    = 15'd0;
        bus.fwd_data  = 96'd0;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", {31'd0, bus.sb_busy}, 32'd0);
        check("reset_err", {31'd0, bus.sb_err}, 32'd0);
        check("reset_stall", {31'd0, bus.id_stall}, 32'd0);

        // forwarding table
        for (int i = 0; i < 8; i++) begin
            bus.ex_rs1    = vecs[i].rs1;
            bus.ex_rs2    = vecs[i].rs2;
            bus.ex_rf1    = vecs[i].rf1;
            bus.ex_rf2    = vecs[i].rf2;
            bus.fwd_valid = vecs[i].valid;
            bus.fwd_rd    = vecs[i].rd;
            bus.fwd_data  = vecs[i].data;
            #1;
            check($sformatf("fwd_op1[%0d]", i), bus.ex_op1, vecs[i].e_op1);
            check($sformatf("fwd_op2[%0d]", i), bus.ex_op2, vecs[i].e_op2);
            check($sformatf("fwd_hit[%0d]", i), {30'd0, bus.ex_fwd_hit}, {30'd0, vecs[i].e_hit});
        end
        bus.fwd_valid = 3'b000;
        tick();

        // flushed long issue must not count
        bus.id_valid    = 1'b1;
        bus.id_rd       = 5'd5;
        bus.id_long_lat = 1'b1;
        bus.id_fire     = 1'b1;
        bus.flush       = 1'b1;
        tick();
        idle();
        check("flush_busy", {31'd0, bus.sb_busy}, 32'd0);
        read_regs(5'd5, 5'd0);
        check("flush_stall", {31'd0, bus.id_stall}, 32'd0);
        idle();

        // load to x7, dependent reader stalls until completion
        issue_long(5'd7);
        check("ld7_busy", {31'd0, bus.sb_busy}, 32'd1);
        read_regs(5'd7, 5'd0);
        check("ld7_stall_a", {31'd0, bus.id_stall}, 32'd1);
        tick();
        check("ld7_stall_b", {31'd0, bus.id_stall}, 32'd1);
        bus.cmp_valid = 1'b1;
        bus.cmp_rd    = 5'd7;
        #1;
        check("ld7_cmp_stall", {31'd0, bus.id_stall}, 32'd0);
        bus.id_fire = 1'b1;
        tick();
        idle();
        check("ld7_busy_clr", {31'd0, bus.sb_busy}, 32'd0);
        check("ld7_err", {31'd0, bus.sb_err}, 32'd0);
        read_regs(5'd7, 5'd7);
        check("ld7_after_stall", {31'd0, bus.id_stall}, 32'd0);
        idle();

        // simultaneous inc and dec on x9
        issue_long(5'd9);
        bus.id_valid    = 1'b1;
        bus.id_rd       = 5'd9;
        bus.id_long_lat = 1'b1;
        bus.cmp_valid   = 1'b1;
        bus.cmp_rd      = 5'd9;
        #1;
        check("x9_both_stall", {31'd0, bus.id_stall}, 32'd0);
        bus.id_fire = 1'b1;
        tick();
        idle();
        check("x9_busy", {31'd0, bus.sb_busy}, 32'd1);
        check("x9_err", {31'd0, bus.sb_err}, 32'd0);
        read_regs(5'd0, 5'd9);
        check("x9_rs2_stall", {31'd0, bus.id_stall}, 32'd1);
        idle();
        complete(5'd9);
        check("x9_busy_clr", {31'd0, bus.sb_busy}, 32'd0);
        check("x9_err_clr", {31'd0, bus.sb_err}, 32'd0);

        // saturate x3
        issue_long(5'd3);
        issue_long(5'd3);
        bus.id_valid    = 1'b1;
        bus.id_rd       = 5'd3;
        bus.id_long_lat = 1'b1;
        #1;
        check("x3_third_stall", {31'd0, bus.id_stall}, 32'd0);
        bus.id_fire = 1'b1;
        tick();
        bus.id_fire = 1'b0;
        #1;
        check("x3_sat_stall", {31'd0, bus.id_stall}, 32'd1);
        bus.cmp_valid = 1'b1;
        bus.cmp_rd    = 5'd3;
        #1;
        check("x3_sat_cmp_stall", {31'd0, bus.id_stall}, 32'd0);
        bus.cmp_valid = 1'b0;
        bus.id_fire   = 1'b1;
        tick();
        idle();
        check("x3_ovf_err", {31'd0, bus.sb_err}, 32'd1);
        check("x3_ovf_busy", {31'd0, bus.sb_busy}, 32'd1);
        tick();
        check("x3_err_sticky", {31'd0, bus.sb_err}, 32'd1);
        complete(5'd3);
        complete(5'd3);
        check("x3_drain_busy", {31'd0, bus.sb_busy}, 32'd1);
        complete(5'd3);
        check("x3_drained", {31'd0, bus.sb_busy}, 32'd0);
        check("x3_err_kept", {31'd0, bus.sb_err}, 32'd1);

        // reset clears error, then underflow on x4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst1_err", {31'd0, bus.sb_err}, 32'd0);
        complete(5'd4);
        check("x4_unf_err", {31'd0, bus.sb_err}, 32'd1);
        check("x4_unf_busy", {31'd0, bus.sb_busy}, 32'd0);

        // mid-operation reset: cnt[3]=2, cnt[7]=1
        issue_long(5'd3);
        issue_long(5'd3);
        issue_long(5'd7);
        check("mid_busy", {31'd0, bus.sb_busy}, 32'd1);
        read_regs(5'd3, 5'd7);
        bus.cmp_valid = 1'b1;
        bus.cmp_rd    = 5'd3;
        #1;
        check("mid_cnt2_cmp_stall", {31'd0, bus.id_stall}, 32'd1);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, bus.sb_busy}, 32'd0);
        check("mid_rst_err", {31'd0, bus.sb_err}, 32'd0);
        read_regs(5'd3, 5'd7);
        check("mid_rst_stall", {31'd0, bus.id_stall}, 32'd0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
